cuckoo_hash_table: RTL

CUCKOO_HASH_TABLE -- requirements
Module: cuckoo_hash_table

---
 rtl/cuckoo_hash_table.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cuckoo_hash_table.sv
// cuckoo_hash_table: H3-hashed multi-table cuckoo store with one stash entry and a valid/ready request/response port
//   clk, reset                 : clock, synchronous active-high reset
//   key_in, data_in            : request key and write payload
//   delete_write_read_i        : 00 nop, 01 read, 10 write, 11 delete
//   valid_i / ready_o          : request handshake (ready only when idle)
//   valid_o / ready_i          : response handshake, response held until ready_i
//   read_data_o, *_o flags     : response payload and status, zero outside a response
//   stash_full_o, count_o      : live occupancy of the stash and of the whole store
module cuckoo_hash_table #(
    parameter int KEY_WIDTH        = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_TABLES = 3,
    parameter int ADR_WIDTH        = 4,
    parameter int MAX_KICKS        = 8,
    parameter logic [NUMBER_OF_TABLES*KEY_WIDTH*ADR_WIDTH-1:0] Q_MATRIX = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            delete_write_read_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  no_element_found_o,
    output logic                  no_deletion_target_o,
    output logic                  no_write_space_o,
    output logic                  key_already_present_o,
    output logic                  stash_full_o,
    output logic [$clog2(NUMBER_OF_TABLES*2**ADR_WIDTH+2)-1:0] count_o
);
    localparam int NT = NUMBER_OF_TABLES;
    localparam int N  = 2**ADR_WIDTH;
    localparam int CW = $clog2(NT*N+2);
    localparam int TW = $clog2(NT);
    localparam int KW = $clog2(MAX_KICKS+1);

    typedef enum logic [1:0] {IDLE, LOOKUP, KICK, RESP} state_t;
    state_t state_q;

    logic [1:0]            op_q;
    logic [KEY_WIDTH-1:0]  req_key_q, cur_key_q;
    logic [DATA_WIDTH-1:0] req_data_q, cur_data_q;
    logic [TW-1:0]         t_q;
    logic [KW-1:0]         kicks_q;
    logic                  tv_q [NT][N];
    logic [KEY_WIDTH-1:0]  tk_q [NT][N];
    logic [DATA_WIDTH-1:0] td_q [NT][N];
    logic                  sv_q;
    logic [KEY_WIDTH-1:0]  sk_q;
    logic [DATA_WIDTH-1:0] sd_q;
    logic                  valid_q, nef_q, ndt_q, nws_q, kap_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    function automatic logic [ADR_WIDTH-1:0] hash(input int t, input logic [KEY_WIDTH-1:0] k);
        hash = '0;
        for (int b = 0; b < ADR_WIDTH; b++)
            for (int i = 0; i < KEY_WIDTH; i++)
                hash[b] ^= k[i] & Q_MATRIX[(t*KEY_WIDTH+i)*ADR_WIDTH+b];
    endfunction

    logic [ADR_WIDTH-1:0]  la [NT];
    logic                  hit, hit_s, emp;
    logic [TW-1:0]         hit_t, emp_t;
    logic [ADR_WIDTH-1:0]  hit_a, emp_a, ka;
    logic [DATA_WIDTH-1:0] hit_d;
    logic [CW-1:0]         cnt;

    // Descending scan so the lowest table index wins both hit and empty-slot selection
    always_comb begin
        hit   = 1'b0;
        hit_t = '0;
        hit_a = '0;
        hit_d = '0;
        emp   = 1'b0;
        emp_t = '0;
        emp_a = '0;
        for (int t = NT-1; t >= 0; t--) begin
            la[t] = hash(t, req_key_q);
            if (tv_q[t][la[t]] && tk_q[t][la[t]] == req_key_q) begin
                hit   = 1'b1;
                hit_t = TW'(t);
                hit_a = la[t];
                hit_d = td_q[t][la[t]];
            end
            if (!tv_q[t][la[t]]) begin
                emp   = 1'b1;
                emp_t = TW'(t);
                emp_a = la[t];
            end
        end
        hit_s = !hit && sv_q && sk_q == req_key_q;
        ka    = hash(int'(t_q), cur_key_q);
        cnt   = CW'(sv_q);
        for (int t = 0; t < NT; t++)
            for (int i = 0; i < N; i++)
                cnt += CW'(tv_q[t][i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int t = 0; t < NT; t++)
                for (int i = 0; i < N; i++)
                    tv_q[t][i] <= 1'b0;
            sv_q    <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            nef_q   <= 1'b0;
            ndt_q   <= 1'b0;
            nws_q   <= 1'b0;
            kap_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (valid_i && delete_write_read_i != 2'b00) begin
                    req_key_q  <= key_in;
                    req_data_q <= data_in;
                    op_q       <= delete_write_read_i;
                    state_q    <= LOOKUP;
                end
                LOOKUP: begin
                    state_q <= RESP;
                    valid_q <= 1'b1;
                    if (op_q == 2'b01) begin
                        if (hit) rdata_q <= hit_d;
                        else if (hit_s) rdata_q <= sd_q;
                        else nef_q <= 1'b1;
                    end else if (op_q == 2'b11) begin
                        if (hit) tv_q[hit_t][hit_a] <= 1'b0;
                        else if (hit_s) sv_q <= 1'b0;
                        else ndt_q <= 1'b1;
                    end else if (hit || hit_s) begin
                        kap_q <= 1'b1;
                    end else if (emp) begin
                        tv_q[emp_t][emp_a] <= 1'b1;
                        tk_q[emp_t][emp_a] <= req_key_q;
                        td_q[emp_t][emp_a] <= req_data_q;
                    end else if (sv_q) begin
                        nws_q <= 1'b1;
                    end else begin
                        state_q    <= KICK;
                        valid_q    <= 1'b0;
                        cur_key_q  <= req_key_q;
                        cur_data_q <= req_data_q;
                        t_q        <= '0;
                        kicks_q    <= '0;
                    end
                end
                KICK: begin
                    if (!tv_q[t_q][ka]) begin
                        tv_q[t_q][ka] <= 1'b1;
                        tk_q[t_q][ka] <= cur_key_q;
                        td_q[t_q][ka] <= cur_data_q;
                        state_q       <= RESP;
                        valid_q       <= 1'b1;
                    end else if (kicks_q == KW'(MAX_KICKS)) begin
                        sv_q    <= 1'b1;
                        sk_q    <= cur_key_q;
                        sd_q    <= cur_data_q;
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end else begin
                        tk_q[t_q][ka] <= cur_key_q;
                        td_q[t_q][ka] <= cur_data_q;
                        cur_key_q     <= tk_q[t_q][ka];
                        cur_data_q    <= td_q[t_q][ka];
                        t_q           <= t_q == TW'(NT-1) ? '0 : t_q + 1'b1;
                        kicks_q       <= kicks_q + 1'b1;
                    end
                end
                RESP: if (ready_i) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    rdata_q <= '0;
                    nef_q   <= 1'b0;
                    ndt_q   <= 1'b0;
                    nws_q   <= 1'b0;
                    kap_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o               = state_q == IDLE;
    assign valid_o               = valid_q;
    assign read_data_o           = rdata_q;
    assign no_element_found_o    = nef_q;
    assign no_deletion_target_o  = ndt_q;
    assign no_write_space_o      = nws_q;
    assign key_already_present_o = kap_q;
    assign stash_full_o          = sv_q;
    assign count_o               = cnt;
endmodule
